button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Producer side of the 4-bit `buttons_export` PIO input of the TimerWithClock system.
- Takes raw, bouncing, active-low board keys and delivers clean, single-cycle press-event pulses to `buttons_export`, one bit per key.
- Synchronises, debounces, detects press edges and, optionally, generates auto-repeat pulses while a key is held, for fast time/alarm setting.
- Sits at top level between the board key pins and the `TimerWithClock` instance.

Parameters:
- NUM_BTN, 4, number of key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 1.
- REPEAT_DELAY, 25000000, hold cycles from the first press pulse to the first repeat pulse (500 ms).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (100 ms).
- ACTIVE_LOW, 1, 1 means raw key pressed = 0; 0 means pressed = 1.

Ports:
- clk_clk  input  1  system clock, same domain as `TimerWithClock`.
- reset_reset  input  1  synchronous, active-high reset.
- keys_raw  input  NUM_BTN  asynchronous raw key pins.
- buttons_export  output  NUM_BTN  registered press-event pulses, one cycle wide per event; feeds `TimerWithClock.buttons_export`.
- buttons_level  output  NUM_BTN  registered debounced level, 1 = pressed.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high on reset_reset, sampled on the rising edge of clk_clk.
  - During reset, all synchroniser flops load the released value.
  - Debounce counters = 0; buttons_level = 0; buttons_export = 0; repeat FSM = RELEASED; repeat counter = 0.
  - Reset asserted mid-hold or mid-debounce aborts everything. After release, a still-held key needs a full DEBOUNCE_CYCLES before its press pulse.
- Polarity: each channel is inverted at the synchroniser input when ACTIVE_LOW=1. Internal logic is active-high.
- Synchroniser: 2-FF per channel. The synchronised sample s[i] lags keys_raw by 2 cycles.
- Debounce, per channel, independent:
  - If s[i] == level[i], the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and s[i] != level[i]: level[i] <= s[i] and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes level.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1); the counter never wraps.
- Press pulse: buttons_export[i] = 1 for exactly the one cycle in which buttons_level[i] first reads 1 after a 0→1 change.
  - Latency from raw change to pulse: 2 + DEBOUNCE_CYCLES cycles.
  - A release produces no pulse.
- Repeat FSM, per channel:
  - States: RELEASED, DELAY, REPEAT.
  - RELEASED→DELAY on the level rise; the press pulse fires and the repeat counter loads 0.
  - DELAY: the counter increments each cycle. When it reaches REPEAT_DELAY-1, emit a pulse, go to REPEAT, counter = 0.
  - REPEAT: the counter increments. When it reaches REPEAT_PERIOD-1, emit a pulse and clear the counter.
  - Any state→RELEASED when level falls; the counter clears and no pulse is issued that cycle.
  - A fall and a repeat terminal count in the same cycle: the fall wins, no pulse.
- Simultaneous keys: channels are fully independent. Any combination of buttons_export bits may be high in the same cycle.

Optional Feature:
- Macro: BUTTON_CONDITIONER_AUTOREPEAT_EN.
- Defined: the repeat FSM above is compiled in.
- Undefined: no repeat FSM or counters; exactly one pulse per debounced press regardless of hold time. buttons_level behaviour is unchanged.

Test Plan:
- All benches use NUM_BTN=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, ACTIVE_LOW=1.
- Reset with keys_raw=4'b1111:
  - Stimulus: hold keys_raw=4'b1111 through reset.
  - Required: buttons_export=0 and buttons_level=0 during reset and for 50 cycles after.
- Clean press, bit0:
  - Stimulus: keys_raw 1111→1110 at cycle 0, then held.
  - Required: buttons_export=4'b0001 for exactly one cycle at cycle 6; buttons_level[0]=1 from cycle 6.
- Bounce:
  - Stimulus: bit1 toggles low/high every 2 cycles for 20 cycles, then stays high.
  - Required: buttons_export[1] and buttons_level[1] stay 0 throughout.
- Auto-repeat (macro defined):
  - Stimulus: hold bit2 low for 60 cycles after its press pulse at cycle P.
  - Required: pulses at P, P+20, P+25, P+30, …, every 5 cycles while held; no pulse after buttons_level[2] falls.
- Auto-repeat (macro undefined):
  - Stimulus: same hold as above.
  - Required: only the single pulse at P.
- Simultaneous press plus reset mid-hold:
  - Stimulus: keys_raw 1111→0000 at cycle 0; assert reset at cycle 10 for 1 cycle, keys still held.
  - Required: buttons_export=4'b1111 at cycle 6; all outputs 0 at cycle 11; next 4'b1111 pulse at cycle 17.

Source files
------------

// File: rtl/button_conditioner.sv
// Key conditioner: 2-FF sync, per-key debounce and single-cycle press pulses.
// Define BUTTON_CONDITIONER_AUTOREPEAT_EN to add hold-to-repeat pulses per key.
module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [NUM_BTN-1:0] keys_raw,
    output logic [NUM_BTN-1:0] buttons_export,
    output logic [NUM_BTN-1:0] buttons_level
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
            $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
        end
    endgenerate

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RELEASED,
        DELAY,
        REPEAT
    } rep_state_t;
`endif

    logic [NUM_BTN-1:0] keys_act;
    logic [NUM_BTN-1:0] sync_q1;
    logic [NUM_BTN-1:0] sync_q2;

    // Polarity is normalised before the synchroniser so everything after is active-high.
    assign keys_act = (ACTIVE_LOW != 0) ? ~keys_raw : keys_raw;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= keys_act;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        logic [DB_W-1:0] db_cnt;
        logic            level_q;
        logic            pulse_q;
        logic            accept;
        logic            rise;
        logic            fall;

        assign accept = (sync_q2[i] != level_q) && (db_cnt == DB_LAST);
        assign rise   = accept && sync_q2[i];
        assign fall   = accept && !sync_q2[i];

        // Any sample matching the current level restarts the stability count.
        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                db_cnt  <= '0;
                level_q <= 1'b0;
            end else if (sync_q2[i] == level_q) begin
                db_cnt <= '0;
            end else if (accept) begin
                level_q <= sync_q2[i];
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
        rep_state_t       rep_state;
        logic [RPT_W-1:0] rep_cnt;

        // A debounced release overrides any terminal count landing in the same cycle.
        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                rep_state <= RELEASED;
                rep_cnt   <= '0;
                pulse_q   <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                if (fall) begin
                    rep_state <= RELEASED;
                    rep_cnt   <= '0;
                end else begin
                    case (rep_state)
                        RELEASED: begin
                            if (rise) begin
                                rep_state <= DELAY;
                                rep_cnt   <= '0;
                                pulse_q   <= 1'b1;
                            end
                        end
                        DELAY: begin
                            if (rep_cnt == DELAY_LAST) begin
                                rep_state <= REPEAT;
                                rep_cnt   <= '0;
                                pulse_q   <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + RPT_W'(1);
                            end
                        end
                        REPEAT: begin
                            if (rep_cnt == PERIOD_LAST) begin
                                rep_cnt <= '0;
                                pulse_q <= 1'b1;
                            end else begin
                                rep_cnt <= rep_cnt + RPT_W'(1);
                            end
                        end
                        default: begin
                            rep_state <= RELEASED;
                            rep_cnt   <= '0;
                        end
                    endcase
                end
            end
        end
`else
        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= rise;
            end
        end
`endif

        assign buttons_level[i]  = level_q;
        assign buttons_export[i] = pulse_q;
    end

endmodule
